incoming_response_buffer: RTL
=============================

INCOMING_RESPONSE_BUFFER -- requirements
Module: incoming_response_buffer

Interface
REQ-001 Parameter ID_WIDTH, default 4, R-channel ID width.
REQ-002 Parameter DATA_WIDTH, default 64, R-channel data width.
REQ-003 Parameter RESP_WIDTH, default 2, R-channel response width.
REQ-004 Parameter DEPTH, default 8, number of beat entries, power of two, at least 2.
REQ-005 Port clk, input, 1, clock, all state on rising edge.
REQ-006 Port rst, input, 1, reset, asynchronous, active-high.
REQ-007 Port r_in, r_if.receiver, ID/DATA/RESP widths plus last/valid/ready, R beats from the AXI slave.
REQ-008 Port r_out, r_if.sender, same widths, R beats toward the r_id_ordering_unit.
REQ-009 Port count, output, $clog2(DEPTH+1), number of beats stored.
REQ-010 Port bursts, output, $clog2(DEPTH+1), number of stored beats with last=1 (complete bursts held).
REQ-011 Port err_seen, output, 1, sticky flag: an accepted beat had resp[1]=1 (SLVERR/DECERR).

Function
REQ-012 The block SHALL be an in-order FIFO of {id, data, resp, last} beats.
REQ-013 r_in.ready SHALL be 1 exactly when count < DEPTH, derived from registered state only and never from r_in.valid.
REQ-014 push SHALL be r_in.valid & r_in.ready; on push, the beat SHALL be written at wr_ptr, and wr_ptr SHALL advance modulo DEPTH.
REQ-015 pop SHALL be r_out.valid & r_out.ready; on pop, rd_ptr SHALL advance modulo DEPTH.
REQ-016 r_out.id/data/resp/last SHALL show the entry at rd_ptr combinationally; values are don't-care while r_out.valid=0.
REQ-017 There SHALL be no bypass: a beat pushed in cycle N is first visible on r_out in cycle N+1.
REQ-018 Pointer and count arithmetic SHALL truncate to declared widths; wrap from DEPTH-1 to 0 SHALL be seamless.
REQ-019 count SHALL follow push-only → +1, pop-only → -1, both or neither → unchanged.
REQ-020 bursts SHALL follow push with last=1 → +1, pop with last=1 → -1, both → unchanged.
REQ-021 When full with pop asserted, r_in.ready SHALL remain 0 in that cycle and no push SHALL occur.
REQ-022 When empty, r_out.valid SHALL be 0 and pop SHALL be impossible.
REQ-023 err_seen SHALL set on push with r_in.resp[1]=1 and SHALL clear only on reset.
REQ-024 While r_out.valid=1 and r_out.ready=0, the r_out payload SHALL remain stable.

Reset
REQ-025 On rst, wr_ptr, rd_ptr, count, bursts and err_seen SHALL go to 0, forcing r_out.valid=0 and r_in.ready=1.
REQ-026 Assertion of rst mid-burst SHALL discard all stored beats; storage contents are not reset.
REQ-027 The first push SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-028 With IRB_BURST_GATE_EN defined, r_out.valid SHALL be (bursts != 0) | (count == DEPTH), giving store-and-forward per burst, with release when full to avoid deadlock on bursts longer than DEPTH.
REQ-029 Without IRB_BURST_GATE_EN, r_out.valid SHALL be (count != 0), giving cut-through.

Structure
REQ-030 Package rob_pkg SHALL hold the r_entry_t packed struct {id, data, resp, last} and the AXI resp encodings OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3.
REQ-031 Storage and pointers SHALL sit in one sub-module rob_sync_fifo (parameterised width and depth, push/pop/full/empty/count); bursts, err_seen and gating SHALL sit in the top module.

Verification
REQ-032 Reset, then push 1 beat (id=3, data=0xA5, last=1) at cycle 0: r_out.valid=1 at cycle 1 with id=3, data=0xA5; count=1; bursts=1.
REQ-033 Push 8 beats with r_out.ready=0: count=8, r_in.ready=0; a 9th valid beat is not accepted; pops return data 0..7 in order.
REQ-034 Full FIFO, r_in.valid=1 and r_out.ready=1 in the same cycle: pop only, count=7; the push occurs in the next cycle.
REQ-035 Continuous push+pop for 20 beats: count stays 1, pointers wrap twice, and output data equals input data delayed by 1 cycle.
REQ-036 IRB_BURST_GATE_EN defined, push 3 beats with last=0,0,1: r_out.valid=0 until the cycle after the third push; with a 10-beat burst, valid rises once count=8.
REQ-037 Push beat with resp=2, then assert rst mid-stream: err_seen=1 until rst; after rst, count=0, bursts=0, err_seen=0, r_out.valid=0.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types for the R-channel response buffer: the beat entry and AXI resp encodings.
package rob_pkg;

   localparam int R_ID_WIDTH   = 4;
   localparam int R_DATA_WIDTH = 64;
   localparam int R_RESP_WIDTH = 2;

   typedef enum logic [1:0] {
      OKAY   = 2'd0,
      EXOKAY = 2'd1,
      SLVERR = 2'd2,
      DECERR = 2'd3
   } axi_resp_e;

   typedef struct packed {
      logic [R_ID_WIDTH-1:0]   id;
      logic [R_DATA_WIDTH-1:0] data;
      logic [R_RESP_WIDTH-1:0] resp;
      logic                    last;
   } r_entry_t;

   // SLVERR and DECERR both carry resp[1]=1.
   function automatic logic resp_is_error(input logic [1:0] resp);
      return resp[1];
   endfunction

endpackage

// File: rtl/r_if.sv
// AXI R-channel handshake bundle; sender drives payload/valid, receiver drives ready.
interface r_if #(
   parameter int ID_WIDTH   = 4,
   parameter int DATA_WIDTH = 64,
   parameter int RESP_WIDTH = 2
);
   logic [ID_WIDTH-1:0]   id;
   logic [DATA_WIDTH-1:0] data;
   logic [RESP_WIDTH-1:0] resp;
   logic                  last;
   logic                  valid;
   logic                  ready;

   modport sender   (output id, data, resp, last, valid, input  ready);
   modport receiver (input  id, data, resp, last, valid, output ready);
endinterface

// File: rtl/rob_sync_fifo.sv
// Synchronous FIFO: unreset storage array, wrapping pointers and an occupancy count.
module rob_sync_fifo #(
   parameter  int WIDTH = 71,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;

   // Storage write; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // Pointer and occupancy update; DEPTH is a power of two so pointers wrap by truncation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push) begin
            wr_ptr_r <= wr_ptr_r + AW'(1'b1);
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + AW'(1'b1);
         end
         case ({push, pop})
            2'b10:   count_r <= count_r + CW'(1'b1);
            2'b01:   count_r <= count_r - CW'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign rdata = mem_r[rd_ptr_r];
   assign full  = (count_r == CW'(DEPTH));
   assign empty = (count_r == {CW{1'b0}});
   assign count = count_r;

endmodule

// File: rtl/incoming_response_buffer.sv
// In-order buffer for R beats from the AXI slave, tracking held bursts and a sticky error flag.
// Define IRB_BURST_GATE_EN to hold beats until a whole burst is stored (released early when full).
module incoming_response_buffer
   import rob_pkg::*;
#(
   parameter  int ID_WIDTH   = 4,
   parameter  int DATA_WIDTH = 64,
   parameter  int RESP_WIDTH = 2,
   parameter  int DEPTH      = 8,
   localparam int CW         = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   r_if.receiver         r_in,
   r_if.sender           r_out,
   output logic [CW-1:0] count,
   output logic [CW-1:0] bursts,
   output logic          err_seen
);

   typedef struct packed {
      logic [ID_WIDTH-1:0]   id;
      logic [DATA_WIDTH-1:0] data;
      logic [RESP_WIDTH-1:0] resp;
      logic                  last;
   } beat_t;

   localparam int WIDTH = $bits(beat_t);

   beat_t         wr_beat_s;
   beat_t         rd_beat_s;
   logic          push_s;
   logic          pop_s;
   logic          full_s;
   logic          empty_s;
   logic          in_ready_s;
   logic          out_valid_s;
   logic [CW-1:0] count_s;
   logic [CW-1:0] bursts_r;
   logic          err_seen_r;

   // Ready depends only on registered occupancy, so a pop never frees a slot in the same cycle.
   assign in_ready_s = !full_s;
   assign push_s     = r_in.valid & in_ready_s;
   assign pop_s      = out_valid_s & r_out.ready;

`ifdef IRB_BURST_GATE_EN
   assign out_valid_s = (bursts_r != {CW{1'b0}}) | full_s;
`else
   assign out_valid_s = !empty_s;
`endif

   assign wr_beat_s.id   = r_in.id;
   assign wr_beat_s.data = r_in.data;
   assign wr_beat_s.resp = r_in.resp;
   assign wr_beat_s.last = r_in.last;

   rob_sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .pop   (pop_s),
      .wdata (wr_beat_s),
      .rdata (rd_beat_s),
      .full  (full_s),
      .empty (empty_s),
      .count (count_s)
   );

   // Count of stored last beats, i.e. complete bursts held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bursts_r <= {CW{1'b0}};
      end else begin
         case ({push_s & r_in.last, pop_s & rd_beat_s.last})
            2'b10:   bursts_r <= bursts_r + CW'(1'b1);
            2'b01:   bursts_r <= bursts_r - CW'(1'b1);
            default: bursts_r <= bursts_r;
         endcase
      end
   end

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_seen_r <= 1'b0;
      end else if (push_s && resp_is_error(r_in.resp[1:0])) begin
         err_seen_r <= 1'b1;
      end else begin
         err_seen_r <= err_seen_r;
      end
   end

   assign r_in.ready  = in_ready_s;
   assign r_out.valid = out_valid_s;
   assign r_out.id    = rd_beat_s.id;
   assign r_out.data  = rd_beat_s.data;
   assign r_out.resp  = rd_beat_s.resp;
   assign r_out.last  = rd_beat_s.last;

   assign count    = count_s;
   assign bursts   = bursts_r;
   assign err_seen = err_seen_r;

endmodule
